// File: rtl/fifo_stream_reader_if.sv
// Bundle of the fifo read port and the outgoing valid/ready stream.
// master = the reader (pops the fifo, drives the stream);
// slave  = the fifo plus downstream consumer side.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  fifo_read_enable;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        input  fifo_empty, fifo_data_out, m_ready,
        output fifo_read_enable, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_data_out, m_ready,
        input  fifo_read_enable, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side companion to the interconnect fifo. Pops words (1-cycle read
// latency) into a 2-entry skid buffer and presents them as a valid/ready
// stream at up to one beat per cycle, flagging every BURST_LEN-th beat as last.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    output logic                 busy,
    fifo_stream_reader_if.master bus
);
    localparam int            BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    logic [DATA_WIDTH-1:0] buffer [2];
    logic [1:0]            count;
    logic                  head;
    logic                  tail;
    logic                  inflight;
    logic [BW-1:0]         beat_cnt;
    logic                  pop;
    logic [2:0]            occupancy;

    // Stream side is a pure function of the buffer state; a read is issued
    // only if the word it returns is guaranteed a free slot next cycle,
    // counting the read already in flight and the slot freed by this pop.
    always_comb begin
        pop                  = bus.m_valid && bus.m_ready;
        occupancy            = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        bus.fifo_read_enable = !rst && enable && !bus.fifo_empty && (occupancy < 3'd2);
    end

    assign bus.m_valid = (count != 2'd0);
    assign bus.m_data  = buffer[head];
    assign bus.m_last  = bus.m_valid && (beat_cnt == LAST_BEAT);
    assign busy        = (count != 2'd0) || inflight;

    // A read issued this cycle returns data next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) inflight <= 1'b0;
        else     inflight <= bus.fifo_read_enable;
    end

    // Capture returning fifo data into the tail slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buffer[0] <= '0;
            buffer[1] <= '0;
        end else if (inflight) begin
            buffer[tail] <= bus.fifo_data_out;
        end
    end

    // Pointer and occupancy bookkeeping; capture+pop together is a no-op on count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (inflight) tail <= ~tail;
            if (pop)      head <= ~head;
            case ({inflight, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Beat position within the burst; survives enable going low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            beat_cnt <= '0;
        else if (pop)
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
    end

    // Sanity: capture into a full buffer with nothing leaving, or a read
    // issued against an empty fifo, would mean the issue rule is broken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(inflight && count == 2'd2 && !pop));
            assert (!(bus.fifo_read_enable && bus.fifo_empty));
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: a behavioural fifo (1-cycle read latency) feeds two readers,
// BURST_LEN=4 (main) and BURST_LEN=1 (boundary), sharing every input.
module tb_fifo_stream_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic busy, busy1;

    fifo_stream_reader_if #(.DATA_WIDTH(32)) bus ();
    fifo_stream_reader_if #(.DATA_WIDTH(32)) bus1 ();

    fifo_stream_reader #(.DATA_WIDTH(32), .BURST_LEN(4)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .busy(busy), .bus(bus)
    );
    fifo_stream_reader #(.DATA_WIDTH(32), .BURST_LEN(1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .busy(busy1), .bus(bus1)
    );

    always #5 clk = ~clk;

    // fifo model
    int          mem [64];
    int          wr_ptr = 0;
    int          rd_ptr;
    logic [31:0] fifo_q = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) rd_ptr <= 0;
        else if (bus.fifo_read_enable) begin
            fifo_q <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    assign bus.fifo_empty     = (rd_ptr == wr_ptr);
    assign bus.fifo_data_out  = fifo_q;
    assign bus1.fifo_empty    = bus.fifo_empty;
    assign bus1.fifo_data_out = bus.fifo_data_out;
    assign bus1.m_ready       = bus.m_ready;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // stream monitor, sampled mid-cycle
    int          rec_d [$];
    bit          rec_l [$];
    int          rec_c [$];
    int          hold_bad = 0, empty_bad = 0, b1_bad = 0;
    bit          hold_armed = 0;
    logic [31:0] hold_d;
    logic        hold_l;

    always @(negedge clk) begin
        if (rst) begin
            hold_armed = 0;
        end else begin
            if (bus.m_valid && bus.m_ready) begin
                rec_d.push_back(bus.m_data);
                rec_l.push_back(bus.m_last);
                rec_c.push_back(cyc);
            end
            if (hold_armed && (bus.m_data !== hold_d || bus.m_last !== hold_l)) hold_bad++;
            if (bus.fifo_read_enable && bus.fifo_empty) empty_bad++;
            if (bus1.m_last !== bus1.m_valid || bus1.m_valid !== bus.m_valid ||
                bus1.m_data !== bus.m_data) b1_bad++;
            hold_armed = bus.m_valid && !bus.m_ready;
            hold_d     = bus.m_data;
            hold_l     = bus.m_last;
        end
    end

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    // Assert reset, preload the fifo, leave the bench at a negedge with rst high.
    task automatic reset_hold(input bit en, input bit rdy, input int first, input int n);
        next();
        rst = 1'b1;
        wr_ptr = 0;
        for (int i = 0; i < n; i++) mem[i] = first + i;
        wr_ptr = n;
        enable = en;
        bus.m_ready = rdy;
        next();
        next();
        rec_d.delete();
        rec_l.delete();
        rec_c.delete();
        look();
    endtask

    task automatic release_rst();
        next();
        rst = 1'b0;
    endtask

    // Compare recorded transfers against first..first+n-1, last on every 4th beat.
    task automatic chk_run(input string tag, input int first, input int n, input bit consec);
        int got_d;
        chk({tag, "_count"}, rec_d.size(), n);
        for (int i = 0; i < n; i++) begin
            got_d = (i < rec_d.size()) ? rec_d[i] : -1;
            chk($sformatf("%s_data%0d", tag, i), got_d, first + i);
            chk($sformatf("%s_last%0d", tag, i), (i < rec_l.size()) ? rec_l[i] : 1'bx, (i % 4) == 3);
            if (consec && i > 0 && i < rec_c.size())
                chk($sformatf("%s_gap%0d", tag, i), rec_c[i] - rec_c[i-1], 1);
        end
    endtask

    initial begin
        bus.m_ready = 1'b0;

        // 1: 1..4 streamed back to back, last on 4
        reset_hold(1, 1, 1, 4);
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_last", bus.m_last, 0);
        chk("rst_data", bus.m_data, 0);
        chk("rst_fre", bus.fifo_read_enable, 0);
        release_rst();
        look();
        chk("t1_fre_first", bus.fifo_read_enable, 1);
        chk("t1_valid_first", bus.m_valid, 0);
        next(); look();
        chk("t1_valid_c1", bus.m_valid, 0);
        chk("t1_busy_c1", busy, 1);
        next(); look();
        chk("t1_valid_c2", bus.m_valid, 1);
        chk("t1_data_c2", bus.m_data, 1);
        chk("t1_last1_c2", bus1.m_last, 1);
        repeat (6) begin next(); look(); end
        chk_run("t1", 1, 4, 1);
        chk("t1_reads", rd_ptr, 4);
        chk("t1_fre_end", bus.fifo_read_enable, 0);
        chk("t1_busy_end", busy, 0);

        // 2: stalled consumer fills the skid buffer with exactly two reads
        reset_hold(1, 0, 1, 6);
        release_rst();
        look();
        repeat (5) begin next(); look(); end
        chk("t2_reads_stall", rd_ptr, 2);
        chk("t2_valid_stall", bus.m_valid, 1);
        chk("t2_data_stall", bus.m_data, 1);
        chk("t2_fre_stall", bus.fifo_read_enable, 0);
        chk("t2_busy_stall", busy, 1);
        next();
        bus.m_ready = 1'b1;
        look();
        repeat (10) begin next(); look(); end
        chk_run("t2", 1, 6, 1);
        chk("t2_reads", rd_ptr, 6);

        // 3: alternating ready, 10..17 delivered once each, last on 13 and 17
        reset_hold(1, 1, 10, 8);
        release_rst();
        look();
        for (int k = 0; k < 40; k++) begin
            next();
            bus.m_ready = (k % 2) == 1;
            look();
        end
        chk_run("t3", 10, 8, 0);
        chk("t3_reads", rd_ptr, 8);

        // 4: enable low holds off reads; first word two cycles after enable
        reset_hold(0, 0, 1, 4);
        release_rst();
        for (int k = 0; k < 4; k++) begin
            look();
            chk($sformatf("t4_fre_off%0d", k), bus.fifo_read_enable, 0);
            chk($sformatf("t4_valid_off%0d", k), bus.m_valid, 0);
            next();
        end
        enable = 1'b1;
        look();
        chk("t4_fre_on", bus.fifo_read_enable, 1);
        chk("t4_valid_on", bus.m_valid, 0);
        next(); look();
        chk("t4_valid_c1", bus.m_valid, 0);
        next(); look();
        chk("t4_valid_c2", bus.m_valid, 1);
        chk("t4_data_c2", bus.m_data, 1);

        // 5: reset with a full buffer at beat 3 clears everything incl. beat count
        reset_hold(1, 1, 1, 5);
        release_rst();
        look();
        repeat (4) begin next(); look(); end
        next();
        bus.m_ready = 1'b0;
        look();
        chk("t5_data_pre", bus.m_data, 4);
        chk("t5_last_pre", bus.m_last, 1);
        next();
        rst = 1'b1;
        wr_ptr = 0;
        mem[0] = 9;
        wr_ptr = 1;
        look();
        chk("t5_valid_rst", bus.m_valid, 0);
        chk("t5_busy_rst", busy, 0);
        chk("t5_last_rst", bus.m_last, 0);
        chk("t5_data_rst", bus.m_data, 0);
        next();
        release_rst();
        look();
        chk("t5_fre_rel", bus.fifo_read_enable, 1);
        next(); look();
        chk("t5_valid_c1", bus.m_valid, 0);
        next(); look();
        chk("t5_valid_c2", bus.m_valid, 1);
        chk("t5_data_c2", bus.m_data, 9);
        chk("t5_last_c2", bus.m_last, 0);

        // 6: invariants observed across the whole run
        chk("hold_rule", hold_bad, 0);
        chk("fre_when_empty", empty_bad, 0);
        chk("burst1_last", b1_bad, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
